// File: rtl/ps2_arrow_decoder.sv
// rtl/ps2_arrow_decoder.sv - PS/2 arrow-key scan-code parser with held mask, active direction and paced movement tick
module ps2_arrow_decoder #(
    parameter int unsigned TICK_DIV     = 2000000,
    parameter int unsigned TIMEOUT      = 65535,
    parameter bit          ACCEPT_PLAIN = 1'b1
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic [7:0] iKEY_DATA,
    input  logic       iKEY_VALID,
    input  logic       iKEY_ERR,
    output logic [7:0] oKEY_CODE,
    output logic [3:0] oHELD,
    output logic       oDIR_VALID,
    output logic       oMOVE_TICK
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    localparam logic [7:0]  CODE_E0   = 8'hE0;
    localparam logic [7:0]  CODE_F0   = 8'hF0;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] to_q, to_d;
    logic [3:0]  held_q, held_d;
    logic [7:0]  code_q, code_d;
    logic        dv_q, dv_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    logic        ev_valid, ev_ext, ev_brk;
    logic [3:0]  key_bit;

    // Held-mask bit order is {down, left, up, right}.
    function automatic logic [3:0] arrow_bit(input logic [7:0] code);
        case (code)
            8'h74:   arrow_bit = 4'b0001;
            8'h75:   arrow_bit = 4'b0010;
            8'h6B:   arrow_bit = 4'b0100;
            8'h72:   arrow_bit = 4'b1000;
            default: arrow_bit = 4'b0000;
        endcase
    endfunction

    function automatic logic [7:0] fallback(input logic [3:0] held);
        if (held[0])      fallback = 8'h74;
        else if (held[1]) fallback = 8'h75;
        else if (held[2]) fallback = 8'h6B;
        else if (held[3]) fallback = 8'h72;
        else              fallback = 8'h00;
    endfunction

    assign key_bit = arrow_bit(iKEY_DATA);

    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        held_d   = held_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        ev_valid = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;

        if (iKEY_ERR) begin
            state_d = S_IDLE;
            to_d    = '0;
        end else if (iKEY_VALID) begin
            to_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (iKEY_DATA == CODE_E0)      state_d = S_EXT;
                    else if (iKEY_DATA == CODE_F0) state_d = S_BRK;
                    else                           ev_valid = 1'b1;
                end
                S_EXT: begin
                    if (iKEY_DATA == CODE_F0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    ev_valid = 1'b1;
                    ev_brk   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    ev_valid = 1'b1;
                    ev_ext   = 1'b1;
                    ev_brk   = 1'b1;
                    state_d  = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (to_q == TO_LAST) begin
                state_d = S_IDLE;
                to_d    = '0;
            end else begin
                to_d = to_q + 16'd1;
            end
        end

        if (ev_valid && (ev_ext || ACCEPT_PLAIN) && (key_bit != 4'b0000)) begin
            if (!ev_brk) begin
                held_d = held_q | key_bit;
                code_d = iKEY_DATA;
            end else if ((held_q & key_bit) != 4'b0000) begin
                held_d = held_q & ~key_bit;
                if (code_q == iKEY_DATA) code_d = fallback(held_q & ~key_bit);
            end
        end

        dv_d = (code_d != 8'h00);

        // Counter only runs while direction stays valid across the edge, so rise starts at 0 and a fall suppresses the tick.
        if (dv_q && dv_d) begin
            if (cnt_q == TICK_LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= S_IDLE;
            to_q    <= '0;
            held_q  <= '0;
            code_q  <= '0;
            dv_q    <= 1'b0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            held_q  <= held_d;
            code_q  <= code_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign oKEY_CODE  = code_q;
    assign oHELD      = held_q;
    assign oDIR_VALID = dv_q;
    assign oMOVE_TICK = tick_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// tb/tb_ps2_arrow_decoder.sv - self-checking bench: directed plan plus random scan-code traffic against a queue-based model
module tb_ps2_arrow_decoder;

    localparam int TD = 8;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kv = 1'b0;
    logic       ke = 1'b0;
    logic [7:0] kd = 8'h00;

    logic [7:0] code_a, code_b;
    logic [3:0] held_a, held_b;
    logic       dv_a, dv_b, tick_a, tick_b;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_arrow_decoder #(.TICK_DIV(TD), .TIMEOUT(TO), .ACCEPT_PLAIN(1'b1)) dut_a (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iKEY_DATA(kd), .iKEY_VALID(kv), .iKEY_ERR(ke),
        .oKEY_CODE(code_a), .oHELD(held_a), .oDIR_VALID(dv_a), .oMOVE_TICK(tick_a)
    );

    ps2_arrow_decoder #(.TICK_DIV(TD), .TIMEOUT(TO), .ACCEPT_PLAIN(1'b0)) dut_b (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iKEY_DATA(kd), .iKEY_VALID(kv), .iKEY_ERR(ke),
        .oKEY_CODE(code_b), .oHELD(held_b), .oDIR_VALID(dv_b), .oMOVE_TICK(tick_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: instance 0 accepts plain arrows, instance 1 does not.
    logic [7:0] arrow_codes [4] = '{8'h74, 8'h75, 8'h6B, 8'h72};
    logic [7:0] pfx [$];
    int         age;
    logic [7:0] m_code [2];
    logic [3:0] m_held [2];
    logic       m_tick [2];
    int         m_on   [2];

    task automatic m_reset();
        pfx.delete();
        age = 0;
        for (int i = 0; i < 2; i++) begin
            m_code[i] = 8'h00;
            m_held[i] = 4'b0000;
            m_tick[i] = 1'b0;
            m_on[i]   = 0;
        end
    endtask

    task automatic m_apply(input int i, input bit ext, input bit brk, input logic [7:0] c);
        int k;
        k = -1;
        for (int j = 0; j < 4; j++) if (arrow_codes[j] == c) k = j;
        if (k < 0) return;
        if (!ext && i == 1) return;
        if (!brk) begin
            m_held[i][k] = 1'b1;
            m_code[i]    = c;
        end else if (m_held[i][k]) begin
            m_held[i][k] = 1'b0;
            if (m_code[i] == c) begin
                m_code[i] = 8'h00;
                for (int j = 3; j >= 0; j--) if (m_held[i][j]) m_code[i] = arrow_codes[j];
            end
        end
    endtask

    task automatic m_step();
        bit was [2];
        bit ext, brk;
        for (int i = 0; i < 2; i++) was[i] = (m_code[i] != 8'h00);
        if (ke) begin
            pfx.delete();
            age = 0;
        end else if (kv) begin
            age = 0;
            if ((pfx.size() == 0 && (kd == 8'hE0 || kd == 8'hF0)) ||
                (pfx.size() == 1 && pfx[0] == 8'hE0 && kd == 8'hF0)) begin
                pfx.push_back(kd);
            end else begin
                ext = 1'b0;
                brk = 1'b0;
                foreach (pfx[j]) begin
                    if (pfx[j] == 8'hE0) ext = 1'b1;
                    if (pfx[j] == 8'hF0) brk = 1'b1;
                end
                pfx.delete();
                m_apply(0, ext, brk, kd);
                m_apply(1, ext, brk, kd);
            end
        end else if (pfx.size() != 0) begin
            age++;
            if (age == TO) begin
                pfx.delete();
                age = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (was[i] && m_code[i] != 8'h00) begin
                m_on[i]++;
                m_tick[i] = (m_on[i] % TD == 0);
            end else begin
                m_on[i]   = 0;
                m_tick[i] = 1'b0;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("code_a", 32'(code_a), 32'(m_code[0]));
            check("held_a", 32'(held_a), 32'(m_held[0]));
            check("dv_a",   32'(dv_a),   32'(m_code[0] != 8'h00));
            check("tick_a", 32'(tick_a), 32'(m_tick[0]));
            check("code_b", 32'(code_b), 32'(m_code[1]));
            check("held_b", 32'(held_b), 32'(m_held[1]));
            check("dv_b",   32'(dv_b),   32'(m_code[1] != 8'h00));
            check("tick_b", 32'(tick_b), 32'(m_tick[1]));
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        kd = b;
        kv = 1'b1;
        tick1();
        kv = 1'b0;
    endtask

    task automatic send_ext(input logic [7:0] b);
        send(8'hE0);
        send(b);
    endtask

    task automatic brk_ext(input logic [7:0] b);
        send(8'hE0);
        send(8'hF0);
        send(b);
    endtask

    logic [7:0] pick [9] = '{8'hE0, 8'hF0, 8'h74, 8'h75, 8'h6B, 8'h72, 8'h1C, 8'hE0, 8'hF0};

    initial begin
        bit any_tick;
        int r;
        repeat (3) tick1();
        check("rst_code", 32'(code_a), 32'h00);
        check("rst_held", 32'(held_a), 32'h0);
        check("rst_dv",   32'(dv_a),   32'h0);
        check("rst_tick", 32'(tick_a), 32'h0);
        rst_n = 1'b1;
        tick1();

        send_ext(8'h74);
        check("e74_code", 32'(code_a), 32'h74);
        check("e74_held", 32'(held_a), 32'h1);
        check("e74_dv",   32'(dv_a),   32'h1);
        for (int k = 1; k <= 25; k++) begin
            tick1();
            check("tick_sched", 32'(tick_a), 32'(k == 8 || k == 16 || k == 24));
        end

        send_ext(8'h75);
        check("mk75_code", 32'(code_a), 32'h75);
        check("mk75_held", 32'(held_a), 32'h3);
        brk_ext(8'h75);
        check("br75_code", 32'(code_a), 32'h74);
        check("br75_held", 32'(held_a), 32'h1);
        brk_ext(8'h74);
        check("br74_code", 32'(code_a), 32'h00);
        check("br74_dv",   32'(dv_a),   32'h0);
        any_tick = 1'b0;
        repeat (20) begin
            tick1();
            if (tick_a) any_tick = 1'b1;
        end
        check("no_tick_idle", 32'(any_tick), 32'h0);

        send_ext(8'h72);
        send_ext(8'h6B);
        brk_ext(8'h6B);
        check("fallback_72", 32'(code_a), 32'h72);
        brk_ext(8'h72);
        send_ext(8'h74);
        send_ext(8'h72);
        send_ext(8'h6B);
        brk_ext(8'h6B);
        check("fallback_74", 32'(code_a), 32'h74);
        check("held_1001",   32'(held_a), 32'h9);
        brk_ext(8'h74);
        brk_ext(8'h72);
        check("cleared", 32'(held_a), 32'h0);

        send(8'h74);
        check("plain_b_code", 32'(code_b), 32'h00);
        check("plain_a_code", 32'(code_a), 32'h74);
        send(8'hF0);
        send(8'h74);
        send(8'h1C);
        check("nonarrow_a", 32'(held_a), 32'h0);
        send_ext(8'h1C);
        check("ext_nonarrow_b", 32'(code_b), 32'h00);

        send_ext(8'h74);
        send(8'hE0);
        repeat (20) tick1();
        send(8'hF0);
        send(8'h74);
        check("timeout_b_held", 32'(held_b), 32'h1);
        check("timeout_a_held", 32'(held_a), 32'h0);
        brk_ext(8'h74);

        send(8'hE0);
        ke = 1'b1;
        tick1();
        ke = 1'b0;
        send(8'h75);
        check("err_a_code", 32'(code_a), 32'h75);
        check("err_b_code", 32'(code_b), 32'h00);
        send(8'hE0);
        ke = 1'b1;
        kv = 1'b1;
        kd = 8'hF0;
        tick1();
        ke = 1'b0;
        kv = 1'b0;
        send(8'h74);
        check("errwin_code", 32'(code_a), 32'h74);
        check("errwin_held", 32'(held_a), 32'h3);

        send_ext(8'h74);
        send(8'hE0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_code_a", 32'(code_a), 32'h00);
        check("arst_held_a", 32'(held_a), 32'h0);
        check("arst_dv_a",   32'(dv_a),   32'h0);
        check("arst_code_b", 32'(code_b), 32'h00);
        tick1();
        rst_n = 1'b1;
        tick1();
        send(8'h74);
        check("post_rst_b", 32'(code_b), 32'h00);
        check("post_rst_a", 32'(code_a), 32'h74);

        for (int it = 0; it < 3000; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                rst_n = 1'b0;
                tick1();
                rst_n = 1'b1;
            end else if (r < 4) begin
                ke = 1'b1;
                kv = 1'($urandom_range(0, 1));
                kd = pick[$urandom_range(0, 8)];
            end else if (r < 40) begin
                kv = 1'b1;
                kd = pick[$urandom_range(0, 8)];
            end else if (r < 43) begin
                repeat ($urandom_range(10, 25)) tick1();
            end
            tick1();
            kv = 1'b0;
            ke = 1'b0;
        end
        repeat (40) tick1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
